// File: rtl/stream_wtrans_pack.sv
// Byte-stream width translator: compacts sparse input beats into a byte FIFO
// and emits prefix-packed output beats that never cross a packet boundary.
module stream_wtrans_pack #(
  parameter int unsigned I_DEXP = 0,
  parameter int unsigned O_DEXP = 0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         itvalid,
  output logic                         itready,
  input  logic [8*(1<<I_DEXP)-1:0]     itdata,
  input  logic [(1<<I_DEXP)-1:0]       itkeep,
  input  logic                         itlast,
  output logic                         otvalid,
  input  logic                         otready,
  output logic [8*(1<<O_DEXP)-1:0]     otdata,
  output logic [(1<<O_DEXP)-1:0]       otkeep,
  output logic                         otlast,
  output logic                         odrop
);

  localparam int unsigned IB  = 1 << I_DEXP;
  localparam int unsigned OB  = 1 << O_DEXP;
  localparam int unsigned MB  = (IB > OB) ? IB : OB;
  localparam int unsigned CAP = 2 * MB;
  localparam int unsigned PW  = $clog2(CAP);
  localparam int unsigned CW  = $clog2(CAP + 1);

  logic [7:0]     mem [CAP];
  logic [CAP-1:0] mark;
  logic [CAP-1:0] mark_next;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;

  logic [CW-1:0]  k;
  logic [CW-1:0]  n;
  logic [CW-1:0]  wofs [IB];
  logic [PW-1:0]  widx [IB];
  logic           accept;
  logic           pop;
  logic           stop;
  logic [PW-1:0]  ridx;

  // Flow control uses registered occupancy only, so no ready/valid loops.
  assign itready = rstn & (count <= CW'(CAP - IB));
  assign otvalid = rstn & ((count >= CW'(OB)) | (|mark));
  assign accept  = itvalid & itready;
  assign pop     = otvalid & otready;

  // Compaction: each kept lane lands at tail + number of kept lanes below it.
  always_comb begin
    k = '0;
    for (int i = 0; i < IB; i++) begin
      wofs[i] = k;
      widx[i] = tail + PW'(wofs[i]);
      if (itkeep[i]) k = k + CW'(1);
    end
  end

  // Output beat: take head bytes up to OB, occupancy, or the first marker.
  always_comb begin
    n      = '0;
    stop   = 1'b0;
    otdata = '0;
    otlast = 1'b0;
    otkeep = '0;
    ridx   = '0;
    for (int j = 0; j < OB; j++) begin
      ridx = head + PW'(j);
      if (!stop && (CW'(j) < count)) begin
        otdata[8*j +: 8] = mem[ridx];
        otlast           = mark[ridx];
        stop             = mark[ridx];
        n                = n + CW'(1);
      end
    end
    for (int j = 0; j < OB; j++) begin
      otkeep[j] = (CW'(j) < n);
    end
  end

  // Markers: clear consumed slots, write fresh ones for appended bytes.
  always_comb begin
    mark_next = mark;
    if (pop) begin
      for (int j = 0; j < OB; j++) begin
        if (CW'(j) < n) mark_next[head + PW'(j)] = 1'b0;
      end
    end
    if (accept) begin
      for (int i = 0; i < IB; i++) begin
        if (itkeep[i]) mark_next[widx[i]] = itlast & (wofs[i] == k - CW'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      mark  <= '0;
      odrop <= 1'b0;
    end else begin
      odrop <= accept & ~(|itkeep);
      count <= count + (accept ? k : CW'(0)) - (pop ? n : CW'(0));
      mark  <= mark_next;
      if (pop)    head <= head + PW'(n);
      if (accept) tail <= tail + PW'(k);
    end
  end

  // Data storage needs no reset; occupancy and markers define validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < IB; i++) begin
        if (itkeep[i]) mem[widx[i]] <= itdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_stream_wtrans_pack.sv
// Bench for stream_wtrans_pack: directed scenarios on three width pairings
// plus randomized traffic checked against a byte-queue reference model.
module tb_stream_wtrans_pack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int checks = 0;
  int errors = 0;

  // Instance A: 1B in, 4B out
  logic a_iv, a_ir, a_il, a_ov, a_or, a_ol, a_dr;
  logic [7:0]  a_id;
  logic [0:0]  a_ik;
  logic [31:0] a_od;
  logic [3:0]  a_ok;
  // Instance B: 4B in, 1B out
  logic b_iv, b_ir, b_il, b_ov, b_or, b_ol, b_dr;
  logic [31:0] b_id;
  logic [3:0]  b_ik;
  logic [7:0]  b_od;
  logic [0:0]  b_ok;
  // Instance C: 4B in, 4B out
  logic c_iv, c_ir, c_il, c_ov, c_or, c_ol, c_dr;
  logic [31:0] c_id;
  logic [3:0]  c_ik;
  logic [31:0] c_od;
  logic [3:0]  c_ok;

  stream_wtrans_pack #(.I_DEXP(0), .O_DEXP(2)) u_a (
    .clk(clk), .rstn(rstn), .itvalid(a_iv), .itready(a_ir), .itdata(a_id),
    .itkeep(a_ik), .itlast(a_il), .otvalid(a_ov), .otready(a_or),
    .otdata(a_od), .otkeep(a_ok), .otlast(a_ol), .odrop(a_dr));

  stream_wtrans_pack #(.I_DEXP(2), .O_DEXP(0)) u_b (
    .clk(clk), .rstn(rstn), .itvalid(b_iv), .itready(b_ir), .itdata(b_id),
    .itkeep(b_ik), .itlast(b_il), .otvalid(b_ov), .otready(b_or),
    .otdata(b_od), .otkeep(b_ok), .otlast(b_ol), .odrop(b_dr));

  stream_wtrans_pack #(.I_DEXP(2), .O_DEXP(2)) u_c (
    .clk(clk), .rstn(rstn), .itvalid(c_iv), .itready(c_ir), .itdata(c_id),
    .itkeep(c_ik), .itlast(c_il), .otvalid(c_ov), .otready(c_or),
    .otdata(c_od), .otkeep(c_ok), .otlast(c_ol), .odrop(c_dr));

  logic        s_ov, s_ir, s_dr, s_ol;
  logic [31:0] s_od;
  logic [3:0]  s_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic smp(input int s);
    case (s)
      0: begin s_ov = a_ov; s_ir = a_ir; s_dr = a_dr; s_ol = a_ol; s_od = a_od; s_ok = a_ok; end
      1: begin s_ov = b_ov; s_ir = b_ir; s_dr = b_dr; s_ol = b_ol;
               s_od = {24'h0, b_od}; s_ok = {3'b0, b_ok}; end
      default: begin s_ov = c_ov; s_ir = c_ir; s_dr = c_dr; s_ol = c_ol; s_od = c_od; s_ok = c_ok; end
    endcase
  endtask

  task automatic drv(input int s, input logic v, input logic [31:0] d,
                     input logic [3:0] k, input logic l, input logic r);
    case (s)
      0: begin a_iv = v; a_id = d[7:0]; a_ik = k[0:0]; a_il = l; a_or = r; end
      1: begin b_iv = v; b_id = d; b_ik = k; b_il = l; b_or = r; end
      default: begin c_iv = v; c_id = d; c_ik = k; c_il = l; c_or = r; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push1(input int s, input logic [31:0] d, input logic [3:0] k, input logic l);
    drv(s, 1'b1, d, k, l, 1'b0);
    step();
    drv(s, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic pop1(input int s);
    drv(s, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    step();
    drv(s, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    for (int s = 0; s < 3; s++) drv(s, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      smp(s);
      chk("rst_itready_low", 32'(s_ir), 32'd0);
      chk("rst_otvalid_low", 32'(s_ov), 32'd0);
    end
    step();
    step();
    smp(0);
    chk("rst_odrop_low", 32'(s_dr), 32'd0);
    rstn = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      smp(s);
      chk("post_rst_itready", 32'(s_ir), 32'd1);
      chk("post_rst_otvalid", 32'(s_ov), 32'd0);
    end
  endtask

  // Reference: a queue of {last, byte}; beats are cut at OB bytes or first last.
  task automatic rand_run(input int s, input int ib, input int ob, input int cyc);
    logic [8:0]  q[$];
    int          cap;
    logic        want_dr;
    int          n, cnt, pushed;
    logic        anyl, wl, want_ov, want_ir, v, l, r, acc;
    logic [31:0] wd, d;
    logic [3:0]  wk, k;
    cap = 2 * ((ib > ob) ? ib : ob);
    want_dr = 1'b0;
    for (int c = 0; c < cyc; c++) begin
      smp(s);
      n = 0; wd = '0; wl = 1'b0; anyl = 1'b0;
      foreach (q[i]) if (q[i][8]) anyl = 1'b1;
      for (int j = 0; j < ob && j < q.size(); j++) begin
        wd[8*j +: 8] = q[j][7:0];
        wl = q[j][8];
        n++;
        if (q[j][8]) break;
      end
      wk = 4'((1 << n) - 1);
      want_ov = (q.size() >= ob) || anyl;
      want_ir = (q.size() <= cap - ib);
      chk("rand_itready", 32'(s_ir), 32'(want_ir));
      chk("rand_otvalid", 32'(s_ov), 32'(want_ov));
      chk("rand_odrop", 32'(s_dr), 32'(want_dr));
      if (want_ov) begin
        chk("rand_otdata", s_od, wd);
        chk("rand_otkeep", 32'(s_ok), 32'(wk));
        chk("rand_otlast", 32'(s_ol), 32'(wl));
      end
      v = ($urandom_range(3) != 0);
      d = $urandom;
      k = 4'($urandom) & ((ib == 1) ? 4'h1 : 4'hF);
      l = ($urandom_range(2) == 0);
      r = ($urandom_range(2) != 0);
      drv(s, v, d, k, l, r);
      acc = v && want_ir;
      if (want_ov && r) repeat (n) void'(q.pop_front());
      if (acc) begin
        cnt = 0;
        for (int i = 0; i < ib; i++) if (k[i]) cnt++;
        pushed = 0;
        for (int i = 0; i < ib; i++) begin
          if (k[i]) begin
            q.push_back({(l && pushed == cnt - 1), d[8*i +: 8]});
            pushed++;
          end
        end
      end
      want_dr = acc && (k == 4'h0);
      step();
    end
    drv(s, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rstn = 1'b0;
    do_reset();

    // 1B -> 4B full beat
    push1(0, 32'h11, 4'h1, 1'b0);
    push1(0, 32'h22, 4'h1, 1'b0);
    push1(0, 32'h33, 4'h1, 1'b0);
    smp(0);
    chk("a_partial_no_valid", 32'(s_ov), 32'd0);
    push1(0, 32'h44, 4'h1, 1'b0);
    smp(0);
    chk("a_full_valid", 32'(s_ov), 32'd1);
    chk("a_full_data", s_od, 32'h44332211);
    chk("a_full_keep", 32'(s_ok), 32'hF);
    chk("a_full_last", 32'(s_ol), 32'd0);
    pop1(0);
    smp(0);
    chk("a_empty_after_pop", 32'(s_ov), 32'd0);

    // 1B -> 4B short packet
    push1(0, 32'hAA, 4'h1, 1'b0);
    push1(0, 32'hBB, 4'h1, 1'b1);
    smp(0);
    chk("a_short_valid", 32'(s_ov), 32'd1);
    chk("a_short_data", s_od, 32'h0000BBAA);
    chk("a_short_keep", 32'(s_ok), 32'h3);
    chk("a_short_last", 32'(s_ol), 32'd1);
    pop1(0);

    // 4B -> 1B, sparse-free keep of three lanes
    push1(1, 32'h44332211, 4'b0111, 1'b1);
    smp(1);
    chk("b_beat0_data", s_od, 32'h11);
    chk("b_beat0_last", 32'(s_ol), 32'd0);
    pop1(1);
    smp(1);
    chk("b_beat1_data", s_od, 32'h22);
    chk("b_beat1_last", 32'(s_ol), 32'd0);
    pop1(1);
    smp(1);
    chk("b_beat2_data", s_od, 32'h33);
    chk("b_beat2_last", 32'(s_ol), 32'd1);
    pop1(1);
    smp(1);
    chk("b_drained", 32'(s_ov), 32'd0);

    // 4B -> 4B sparse keep and drop
    push1(2, 32'hDDCCBBAA, 4'b1010, 1'b1);
    smp(2);
    chk("c_sparse_data", s_od, 32'h0000DDBB);
    chk("c_sparse_keep", 32'(s_ok), 32'h3);
    chk("c_sparse_last", 32'(s_ol), 32'd1);
    pop1(2);
    push1(2, 32'h12345678, 4'b0000, 1'b1);
    smp(2);
    chk("c_drop_pulse", 32'(s_dr), 32'd1);
    chk("c_drop_no_out", 32'(s_ov), 32'd0);
    step();
    smp(2);
    chk("c_drop_one_cycle", 32'(s_dr), 32'd0);

    // Backpressure: fill A, then one pop restores ready
    for (int i = 1; i <= 8; i++) push1(0, 32'(i), 4'h1, 1'b0);
    smp(0);
    chk("a_full_itready", 32'(s_ir), 32'd0);
    chk("a_stall_data", s_od, 32'h04030201);
    pop1(0);
    smp(0);
    chk("a_ready_restored", 32'(s_ir), 32'd1);
    chk("a_second_data", s_od, 32'h08070605);
    pop1(0);

    // Concurrent push and pop on C keeps occupancy constant
    push1(2, 32'h04030201, 4'hF, 1'b0);
    drv(2, 1'b1, 32'h08070605, 4'hF, 1'b0, 1'b1);
    step();
    drv(2, 1'b1, 32'h0C0B0A09, 4'hF, 1'b0, 1'b1);
    step();
    drv(2, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    smp(2);
    chk("c_pp_valid", 32'(s_ov), 32'd1);
    chk("c_pp_data", s_od, 32'h0C0B0A09);
    chk("c_pp_itready", 32'(s_ir), 32'd1);
    pop1(2);
    smp(2);
    chk("c_pp_drained", 32'(s_ov), 32'd0);

    // Reset mid-packet discards buffered bytes
    push1(0, 32'h01, 4'h1, 1'b0);
    push1(0, 32'h02, 4'h1, 1'b0);
    push1(0, 32'h03, 4'h1, 1'b0);
    do_reset();
    push1(0, 32'h55, 4'h1, 1'b0);
    push1(0, 32'h66, 4'h1, 1'b1);
    smp(0);
    chk("a_post_rst_data", s_od, 32'h00006655);
    chk("a_post_rst_keep", 32'(s_ok), 32'h3);
    chk("a_post_rst_last", 32'(s_ol), 32'd1);

    do_reset();
    rand_run(0, 1, 4, 400);
    do_reset();
    rand_run(1, 4, 1, 400);
    do_reset();
    rand_run(2, 4, 4, 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
